// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte producers / uart core and uart_tx_arbiter.
// Optional macro: UART_ARB_LOCK_EN adds the per-requester lock input.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_byte;
  logic              tx_req;
  logic              tx_busy;
  logic              active;
  logic [GW-1:0]     grant_id;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   lock;

  modport master (
    output req, req_data, tx_busy, lock,
    input  ack, tx_byte, tx_req, active, grant_id
  );

  modport slave (
    input  req, req_data, tx_busy, lock,
    output ack, tx_byte, tx_req, active, grant_id
  );
`else
  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_byte, tx_req, active, grant_id
  );

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_byte, tx_req, active, grant_id
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart transmitter between NREQ producers.
// A grant latches the winner's byte, strobes tx_req/ack for one cycle, then
// follows tx_busy (with a rise timeout) until the frame has left the wire.
// Optional macro: UART_ARB_LOCK_EN lets the last granted requester keep the
// transmitter for consecutive bytes while its lock bit is high.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        cnt_r;
  logic [7:0]        cnt_nxt_s;
  logic [NREQ-1:0]   ack_r;
  logic [NREQ-1:0]   ack_nxt_s;
  logic              tx_req_r;
  logic              tx_req_nxt_s;
  logic [7:0]        tx_byte_r;
  logic [7:0]        tx_byte_nxt_s;
  logic [GW-1:0]     grant_r;
  logic [GW-1:0]     grant_nxt_s;
  logic              active_r;

  logic              rr_found_s;
  logic [GW-1:0]     rr_winner_s;
  logic              lock_hit_s;
  logic              found_s;
  logic [GW-1:0]     winner_s;
  logic [GW:0]       sum_s;

`ifdef UART_ARB_LOCK_EN
  // Remembers that grant_r names a real grant (not the reset pointer value).
  logic granted_r;

  // Track whether any grant happened since reset, so lock only follows a real owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      granted_r <= 1'b0;
    end else if (state_r == IDLE && state_nxt_s == WAIT_BUSY) begin
      granted_r <= 1'b1;
    end else begin
      granted_r <= granted_r;
    end
  end

  assign lock_hit_s = granted_r & bus.lock[grant_r] & bus.req[grant_r];
`else
  assign lock_hit_s = 1'b0;
`endif

  // Round-robin search: first pending index after the last grant, wrapping.
  always_comb begin
    rr_found_s  = 1'b0;
    rr_winner_s = '0;
    sum_s       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum_s = {1'b0, grant_r} + (GW+1)'(k);
      if (sum_s >= (GW+1)'(NREQ)) begin
        sum_s = sum_s - (GW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      if (!rr_found_s && bus.req[sum_s[GW-1:0]]) begin
        rr_found_s  = 1'b1;
        rr_winner_s = sum_s[GW-1:0];
      end else begin
        rr_found_s  = rr_found_s;
        rr_winner_s = rr_winner_s;
      end
    end
  end

  // A locked owner with a pending byte overrides the round-robin choice.
  always_comb begin
    if (lock_hit_s) begin
      found_s  = 1'b1;
      winner_s = grant_r;
    end else begin
      found_s  = rr_found_s;
      winner_s = rr_winner_s;
    end
  end

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    ack_nxt_s     = '0;
    tx_req_nxt_s  = 1'b0;
    tx_byte_nxt_s = tx_byte_r;
    grant_nxt_s   = grant_r;
    case (state_r)
      IDLE: begin
        if (!bus.tx_busy && found_s) begin
          state_nxt_s   = WAIT_BUSY;
          cnt_nxt_s     = 8'd0;
          tx_req_nxt_s  = 1'b1;
          ack_nxt_s     = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
          tx_byte_nxt_s = bus.req_data[{winner_s, 3'b000} +: 8];
          grant_nxt_s   = winner_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt_s = WAIT_DONE;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r + 8'd1 == 8'(BUSY_TIMEOUT)) begin
          // uart never acknowledged: treat the byte as sent, no retry
          state_nxt_s = IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State register and registered outputs; reset abandons any frame tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      ack_r     <= '0;
      tx_req_r  <= 1'b0;
      tx_byte_r <= 8'h00;
      grant_r   <= GW'(NREQ - 1);
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ack_r     <= ack_nxt_s;
      tx_req_r  <= tx_req_nxt_s;
      tx_byte_r <= tx_byte_nxt_s;
      grant_r   <= grant_nxt_s;
      active_r  <= (state_nxt_s != IDLE);
    end
  end

  assign bus.ack      = ack_r;
  assign bus.tx_req   = tx_req_r;
  assign bus.tx_byte  = tx_byte_r;
  assign bus.grant_id = grant_r;
  assign bus.active   = active_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand sequences,
// with a queue of expected grants compared whenever tx_req appears.
module tb_uart_tx_arbiter;
  localparam int NREQ         = 4;
  localparam int BUSY_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_v = 4'b0000;
  logic [31:0] req_data_v = 32'h0;
  logic [3:0]  drop_mask = 4'b0000;
  logic        uart_busy = 1'b0;
  int          busy_len = 10;
  int          busy_cnt = 0;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  lock_v = 4'b0000;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          busy;
    logic [1:0]  id;
    logic [7:0]  exp_byte;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[7];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus_if();

  assign bus_if.req      = req_v;
  assign bus_if.req_data = req_data_v;
  assign bus_if.tx_busy  = uart_busy;
`ifdef UART_ARB_LOCK_EN
  assign bus_if.lock     = lock_v;
`endif

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // uart model: busy for busy_len cycles after each tx_req (0 = never busy)
  always @(negedge clk) begin
    if (bus_if.tx_req && busy_len > 0) begin
      uart_busy = 1'b1;
      busy_cnt  = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard compare plus requester drop-on-ack, called at every negedge
  task automatic monitor_step();
    exp_t       e;
    logic [3:0] one_v;
    if (bus_if.tx_req) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_grant: tx_byte %0h grant_id %0d, no grant expected",
                 bus_if.tx_byte, bus_if.grant_id);
      end else begin
        e     = exp_q.pop_front();
        one_v = 4'b0001 << e.id;
        if (bus_if.tx_byte !== e.data || bus_if.grant_id !== e.id || bus_if.ack !== one_v) begin
          n_err++;
          $display("FAIL grant: got byte %0h id %0d ack %b, expected byte %0h id %0d ack %b",
                   bus_if.tx_byte, bus_if.grant_id, bus_if.ack, e.data, e.id, one_v);
        end
      end
    end else if (bus_if.ack !== 4'b0000) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_without_txreq: ack %b tx_req %b", bus_if.ack, bus_if.tx_req);
    end
    req_v = req_v & ~(bus_if.ack & drop_mask);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor_step();
    end
  endtask

  // run until queue is down to target and the arbiter is idle; n = active cycles
  task automatic wait_frame(input int target, output int n);
    bit done = 1'b0;
    n = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      monitor_step();
      if (bus_if.active) n++;
      if (exp_q.size() <= target && !bus_if.active) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: queue %0d active %b, expected queue %0d and idle",
               exp_q.size(), bus_if.active, target);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},      32'(bus_if.ack),      32'h0);
    chk({tag, "_tx_req"},   32'(bus_if.tx_req),   32'h0);
    chk({tag, "_tx_byte"},  32'(bus_if.tx_byte),  32'h00);
    chk({tag, "_active"},   32'(bus_if.active),   32'h0);
    chk({tag, "_grant_id"}, 32'(bus_if.grant_id), 32'h3);
  endtask

  initial begin
    int n;

    tbl[0] = '{4'b1111, 32'h44434241, 10, 2'd0, 8'h41};
    tbl[1] = '{4'b1111, 32'h44434241, 10, 2'd1, 8'h42};
    tbl[2] = '{4'b1111, 32'h44434241, 10, 2'd2, 8'h43};
    tbl[3] = '{4'b1111, 32'h44434241, 10, 2'd3, 8'h44};
    tbl[4] = '{4'b1111, 32'h44434241, 10, 2'd0, 8'h41};
    tbl[5] = '{4'b0100, 32'h005A0000, 10, 2'd2, 8'h5A};
    tbl[6] = '{4'b0100, 32'h005B0000, 10, 2'd2, 8'h5B};

    // reset held 3 cycles with every requester pending
    reset      = 1'b1;
    req_v      = 4'b1111;
    req_data_v = 32'h44434241;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_outputs("reset_hold");
    end
    reset = 1'b0;

    // table: round-robin fairness, then single requester back-to-back
    for (int v = 0; v < 7; v++) begin
      req_v      = tbl[v].req;
      req_data_v = tbl[v].data;
      busy_len   = tbl[v].busy;
      push(tbl[v].id, tbl[v].exp_byte);
      wait_frame(0, n);
    end
    req_v = 4'b0000;

    // uart never goes busy: each frame ends after exactly BUSY_TIMEOUT cycles
    busy_len   = 0;
    drop_mask  = 4'b1111;
    req_data_v = 32'h7D000077 | 32'h00000000;
    req_data_v[15:8]  = 8'h77;
    req_data_v[31:24] = 8'h7D;
    req_v      = 4'b1010;
    push(2'd3, 8'h7D);
    push(2'd1, 8'h77);
    wait_frame(1, n);
    chk("timeout_len_first", 32'(n), 32'(BUSY_TIMEOUT));
    wait_frame(0, n);
    chk("timeout_len_second", 32'(n), 32'(BUSY_TIMEOUT));
    chk("timeout_req_left", 32'(req_v), 32'h0);

    // reset during WAIT_DONE with requester 1 pending
    busy_len   = 10;
    req_data_v = 32'h00009190;
    req_v      = 4'b0001;
    push(2'd0, 8'h90);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick(1);
    chk("mid_first_popped", 32'(exp_q.size()), 32'h0);
    req_v = req_v | 4'b0010;
    tick(3);
    chk("mid_in_frame", 32'(bus_if.active), 32'h1);
    reset = 1'b1;
    tick(1);
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    push(2'd1, 8'h91);
    wait_frame(0, n);
    tick(20);
    chk("mid_no_dup_req", 32'(req_v), 32'h0);
    chk("mid_no_dup_queue", 32'(exp_q.size()), 32'h0);

`ifdef UART_ARB_LOCK_EN
    // requester 3 keeps the transmitter for 3 bytes while 0 waits
    drop_mask  = 4'b0001;
    lock_v     = 4'b1000;
    req_data_v = 32'hD00000A0;
    req_v      = 4'b1001;
    push(2'd3, 8'hD0);
    push(2'd3, 8'hD1);
    push(2'd3, 8'hD2);
    push(2'd0, 8'hA0);
    wait_frame(3, n);
    req_data_v[31:24] = 8'hD1;
    wait_frame(2, n);
    req_data_v[31:24] = 8'hD2;
    wait_frame(1, n);
    lock_v = 4'b0000;
    req_v  = req_v & 4'b0111;
    wait_frame(0, n);
    tick(5);
    chk("lock_queue_empty", 32'(exp_q.size()), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
